// File: rtl/sda_rx_pkg.sv
// Shared I2C definitions: receive FSM encoding and byte geometry, common to
// the receive path and the transmit-side blocks.
package sda_rx_pkg;

    localparam int BYTE_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_BITS   = 3'd1,
        ST_BYTE_DONE = 3'd2,
        ST_ACK_WAIT  = 3'd3,
        ST_ACK_SLOT  = 3'd4
    } rx_state_e;

    typedef logic [3:0]           bit_cnt_t;
    typedef logic [BYTE_BITS-1:0] byte_t;

    // Bus order is MSB first, so each new bit enters at the LSB end.
    function automatic byte_t shift_in(input byte_t sr, input logic b);
        return {sr[BYTE_BITS-2:0], b};
    endfunction

endpackage

// File: rtl/sda_rx_if.sv
// Link between the pin synchronizer/edge detector and the receive FSM:
// raw pins in, single-cycle bus events out.
interface sda_rx_if;
    logic scl;
    logic sda_in;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_bit;

    modport master (
        input  scl, sda_in,
        output scl_rise, scl_fall, start_det, stop_det, sda_bit
    );

    modport slave (
        input  scl_rise, scl_fall, start_det, stop_det, sda_bit
    );
endinterface

// File: rtl/sda_rx_scl_sda_edge.sv
// Synchronizes SCL/SDA into clk and flags SCL edges plus START/STOP, using
// only the synchronized value and one "previous" copy of each line.
module scl_sda_edge #(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic      clk,
    input  logic      n_rst,
    sda_rx_if.master  bus
);
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Reset to 1 so that an idle bus is what the detector sees after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of the stage before it, which is what makes this a chain.
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    assign bus.scl_rise  = ~r_scl_prev &  w_scl;
    assign bus.scl_fall  =  r_scl_prev & ~w_scl;
    assign bus.start_det =  r_scl_prev &  w_scl &  r_sda_prev & ~w_sda;
    assign bus.stop_det  =  r_scl_prev &  w_scl & ~r_sda_prev &  w_sda;
    assign bus.sda_bit   =  w_sda;

endmodule

// File: rtl/sda_rx.sv
// I2C receive path: assembles bytes MSB first from SCL/SDA and frames the
// 9th (ACK) bit so the controller can drive SDA low during it.
module sda_rx
    import sda_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic [7:0] rx_data,
    output logic       byte_received,
    output logic       start_found,
    output logic       stop_found,
    output logic       ack_window,
    output logic       busy
);
    sda_rx_if w_bus ();

    assign w_bus.scl    = scl;
    assign w_bus.sda_in = sda_in;

    scl_sda_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (w_bus)
    );

    rx_state_e r_state;
    bit_cnt_t  r_bit_cnt;
    byte_t     r_shift;
    byte_t     r_rx_data;
    logic      r_byte_received;
    logic      r_start_found;
    logic      r_stop_found;
    logic      r_ack_window;
    logic      r_busy;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= ST_IDLE;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_rx_data       <= '0;
            r_byte_received <= 1'b0;
            r_start_found   <= 1'b0;
            r_stop_found    <= 1'b0;
            r_ack_window    <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle; only the branch that
            // fires raises one, so each lasts exactly one clk.
            r_byte_received <= 1'b0;
            r_start_found   <= 1'b0;
            r_stop_found    <= 1'b0;

            // START/STOP need SCL steady high, so they never coincide with
            // an SCL edge and may safely preempt the state logic.
            if (w_bus.start_det) begin
                r_start_found <= 1'b1;
                r_state       <= ST_RX_BITS;
                r_bit_cnt     <= '0;
                r_shift       <= '0;
                r_ack_window  <= 1'b0;
                r_busy        <= 1'b1;
            end else if (w_bus.stop_det) begin
                r_stop_found <= 1'b1;
                if (r_state != ST_IDLE) begin
                    r_state      <= ST_IDLE;
                    r_bit_cnt    <= '0;
                    r_ack_window <= 1'b0;
                    r_busy       <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: ;

                    ST_RX_BITS: begin
                        if (w_bus.scl_rise) begin
                            r_shift   <= shift_in(r_shift, w_bus.sda_bit);
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == bit_cnt_t'(BYTE_BITS - 1))
                                r_state <= ST_BYTE_DONE;
                        end
                    end

                    ST_BYTE_DONE: begin
                        r_rx_data       <= r_shift;
                        r_byte_received <= 1'b1;
                        r_state         <= ST_ACK_WAIT;
                    end

                    // Falling edge of bit 8 opens the ACK bit.
                    ST_ACK_WAIT: begin
                        if (w_bus.scl_fall) begin
                            r_ack_window <= 1'b1;
                            r_state      <= ST_ACK_SLOT;
                        end
                    end

                    // The only fall seen here follows the 9th rise.
                    ST_ACK_SLOT: begin
                        if (w_bus.scl_fall) begin
                            r_ack_window <= 1'b0;
                            r_bit_cnt    <= '0;
                            r_state      <= ST_RX_BITS;
                        end
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign byte_received = r_byte_received;
    assign start_found   = r_start_found;
    assign stop_found    = r_stop_found;
    assign ack_window    = r_ack_window;
    assign busy          = r_busy;

endmodule

// File: tb/tb_sda_rx.sv
// Bench for sda_rx: drives I2C frames on the pins, predicts every output
// each clk from a protocol-level model, and pins the model with literals.
module tb_sda_rx;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    sda_rx_if tb_if ();

    logic [7:0] rx_data;
    logic       byte_received;
    logic       start_found;
    logic       stop_found;
    logic       ack_window;
    logic       busy;

    sda_rx #(
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .scl           (tb_if.scl),
        .sda_in        (tb_if.sda_in),
        .rx_data       (rx_data),
        .byte_received (byte_received),
        .start_found   (start_found),
        .stop_found    (stop_found),
        .ack_window    (ack_window),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cnt_start, cnt_stop, cnt_byte, cnt_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Pins are sampled at each posedge; an output
    // registered at edge n reflects the pin change between samples n-3 and
    // n-2 (two synchronizer stages, then the registered output).
    // ------------------------------------------------------------------
    logic [1:0] p0, p1, p2, p3;   // {scl, sda} at edges n, n-1, n-2, n-3
    bit         m_busy, m_ack, m_pending;
    int         m_phase;          // 0: data bits, 1: waiting end of bit 8, 2: ACK bit
    bit         m_bits[$];
    logic [7:0] m_rx;
    bit         m_start, m_stop, m_byte;

    function automatic logic [7:0] pack_bits(input bit bits[$]);
        logic [7:0] v = 8'h00;
        foreach (bits[i]) v = v * 2 + 8'(bits[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        if (!n_rst) begin
            p0 = 2'b11; p1 = 2'b11; p2 = 2'b11; p3 = 2'b11;
            m_busy = 0; m_ack = 0; m_pending = 0; m_phase = 0;
            m_bits.delete();
            m_rx = 8'h00;
            m_start = 0; m_stop = 0; m_byte = 0;
        end else begin
            p3 = p2; p2 = p1; p1 = p0; p0 = {tb_if.scl, tb_if.sda_in};
            tb_if.scl_rise  = !p3[1] && p2[1];
            tb_if.scl_fall  = p3[1] && !p2[1];
            tb_if.start_det = p3[1] && p2[1] && p3[0] && !p2[0];
            tb_if.stop_det  = p3[1] && p2[1] && !p3[0] && p2[0];
            tb_if.sda_bit   = p2[0];
            m_start = tb_if.start_det;
            m_stop  = tb_if.stop_det;
            m_byte  = 0;
            if (m_start) begin
                m_busy = 1; m_ack = 0; m_phase = 0; m_pending = 0;
                m_bits.delete();
            end else if (m_stop) begin
                m_busy = 0; m_ack = 0; m_phase = 0; m_pending = 0;
                m_bits.delete();
            end else if (m_pending) begin
                m_pending = 0;
                m_byte    = 1;
                m_rx      = pack_bits(m_bits);
                m_bits.delete();
                m_phase   = 1;
            end else if (m_busy) begin
                if (m_phase == 0 && tb_if.scl_rise) begin
                    m_bits.push_back(tb_if.sda_bit);
                    if (m_bits.size() == 8) m_pending = 1;
                end else if (m_phase == 1 && tb_if.scl_fall) begin
                    m_ack = 1; m_phase = 2;
                end else if (m_phase == 2 && tb_if.scl_fall) begin
                    m_ack = 0; m_phase = 0;
                end
            end
        end
        #1;
        check("rx_data", {24'h0, rx_data}, {24'h0, m_rx});
        check("byte_received", {31'h0, byte_received}, {31'h0, m_byte});
        check("start_found", {31'h0, start_found}, {31'h0, m_start});
        check("stop_found", {31'h0, stop_found}, {31'h0, m_stop});
        check("ack_window", {31'h0, ack_window}, {31'h0, m_ack});
        check("busy", {31'h0, busy}, {31'h0, m_busy});
        if (start_found)   cnt_start++;
        if (stop_found)    cnt_stop++;
        if (byte_received) cnt_byte++;
        if (ack_window)    cnt_ack++;
    end

    // ------------------------------------------------------------------
    // Pin drivers: all changes happen right after a negedge. SCL period is
    // 40 clk (20 low, 20 high); SDA only moves mid-low unless framing.
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        cnt_start = 0; cnt_stop = 0; cnt_byte = 0; cnt_ack = 0;
    endtask

    task automatic send_start();
        tb_if.sda_in = 1'b1; tick(10);
        tb_if.scl    = 1'b1; tick(10);
        tb_if.sda_in = 1'b0; tick(10);
        tb_if.scl    = 1'b0; tick(10);
    endtask

    task automatic send_stop();
        tb_if.sda_in = 1'b0; tick(10);
        tb_if.scl    = 1'b1; tick(10);
        tb_if.sda_in = 1'b1; tick(10);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        if (glitch) begin
            tb_if.sda_in = ~b; tick(2);
            tb_if.sda_in = b;  tick(2);
            tb_if.sda_in = ~b; tick(1);
            tb_if.sda_in = b;  tick(5);
        end else begin
            tb_if.sda_in = b;  tick(10);
        end
        tb_if.scl = 1'b1; tick(20);
        tb_if.scl = 1'b0; tick(10);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit glitch);
        for (int i = 7; i >= 0; i--) send_bit(v[i], glitch);
        send_bit(1'b0, 1'b0);   // ACK bit, SDA held low as the controller would
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tb_if.scl = 1'b1;
        tb_if.sda_in = 1'b1;
        clear_counts();
        tick(4);
        check("reset_rx_data", {24'h0, rx_data}, 32'h00);
        check("reset_outputs", {26'h0, byte_received, start_found, stop_found, ack_window, busy}, 32'h0);
        n_rst = 1'b1;
        tick(10);

        // START latency: first pulse on the 3rd posedge after the SDA fall.
        clear_counts();
        tb_if.sda_in = 1'b0;
        @(posedge clk); #1 check("start_edge1", {31'h0, start_found}, 32'h0);
        @(posedge clk); #1 check("start_edge2", {31'h0, start_found}, 32'h0);
        @(posedge clk); #1 check("start_edge3", {31'h0, start_found}, 32'h1);
        @(posedge clk); #1 check("start_edge4", {31'h0, start_found}, 32'h0);
        @(negedge clk);
        tick(5);
        tb_if.scl = 1'b0;
        tick(10);
        send_byte(8'hA5, 1'b0);
        check("a5_starts", cnt_start, 1);
        check("a5_bytes", cnt_byte, 1);
        check("a5_rx", {24'h0, rx_data}, 32'hA5);
        check("a5_ack_cycles", cnt_ack, 40);

        clear_counts();
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_stop();
        tick(5);
        check("two_bytes", cnt_byte, 2);
        check("two_rx", {24'h0, rx_data}, 32'hFF);
        check("two_stops", cnt_stop, 1);
        check("two_busy", {31'h0, busy}, 32'h0);

        clear_counts();
        send_start();
        send_bits(8'h05, 4);
        send_start();
        send_byte(8'h81, 1'b0);
        check("rs_bytes", cnt_byte, 1);
        check("rs_rx", {24'h0, rx_data}, 32'h81);
        check("rs_starts", cnt_start, 2);
        send_stop();
        tick(5);

        clear_counts();
        send_start();
        send_bits(8'h16, 5);
        send_stop();
        tick(5);
        check("part_rx", {24'h0, rx_data}, 32'h81);
        check("part_bytes", cnt_byte, 0);
        check("part_ack", cnt_ack, 0);
        check("part_stops", cnt_stop, 1);
        check("part_busy", {31'h0, busy}, 32'h0);

        // Reset during bit 3, then a byte with no START must be ignored.
        send_start();
        send_bits(8'h02, 2);
        tb_if.sda_in = 1'b1; tick(10);
        tb_if.scl = 1'b1; tick(8);
        n_rst = 1'b0;
        tb_if.scl = 1'b0;
        tick(5);
        n_rst = 1'b1;
        tick(10);
        clear_counts();
        send_byte(8'h12, 1'b0);
        check("nostart_rx", {24'h0, rx_data}, 32'h00);
        check("nostart_pulses", cnt_byte + cnt_start + cnt_stop + cnt_ack, 0);
        send_start();
        send_byte(8'h34, 1'b0);
        check("after_rst_rx", {24'h0, rx_data}, 32'h34);
        check("after_rst_bytes", cnt_byte, 1);
        send_stop();
        tick(5);

        clear_counts();
        send_start();
        send_byte(8'h96, 1'b1);
        send_stop();
        tick(5);
        check("glitch_starts", cnt_start, 1);
        check("glitch_stops", cnt_stop, 1);
        check("glitch_rx", {24'h0, rx_data}, 32'h96);

        // Random frames: bytes, glitches, partial bytes, STOP or repeated START.
        for (int f = 0; f < 10; f++) begin
            int nb;
            send_start();
            nb = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++)
                send_byte(8'($urandom), $urandom_range(0, 3) == 0);
            send_bits(8'($urandom), $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) send_stop();
        end
        send_stop();
        tick(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
